// File: rtl/wm_block_raster_collector.sv
// Reorders block-order pixels into a raster image bank and serves it over APB reads (1-cycle read latency, no backpressure).
// Define REORDER_PACK_EN to pack Amba_Word/Data_Depth pixels per APB word; otherwise one zero-extended pixel per word.
module wm_block_raster_collector #(
  parameter int Amba_Word       = 16,
  parameter int Amba_Addr_Depth = 20,
  parameter int Data_Depth      = 8,
  parameter int Block_Depth     = 7,
  parameter int Max_Img_Size    = 720
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_load,
  input  logic [9:0]                 Np,
  input  logic [Block_Depth-1:0]     M,
  input  logic                       new_pixel,
  input  logic [Data_Depth-1:0]      Pixel_Data,
  input  logic                       Image_Done,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [Amba_Addr_Depth-1:0] PADDR,
  output logic [Amba_Word-1:0]       PRDATA,
  output logic                       frame_ready,
  output logic                       cfg_err,
  output logic                       overflow,
  output logic                       short_frame
);

  localparam int AW    = Amba_Addr_Depth;
  localparam int BD    = Block_Depth;
  localparam int DD    = Data_Depth;
  localparam int DEPTH = Max_Img_Size * Max_Img_Size;
  localparam int BA_W  = $clog2(DEPTH);
  localparam int P     = Amba_Word / Data_Depth;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_READY   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [9:0]          np_q, np_d;
  logic [BD-1:0]       m_q, m_d;
  logic [9:0]          nb_q, nb_d;
  logic [AW-1:0]       npsq_q, npsq_d;
  logic [AW-1:0]       stride_q, stride_d;
  logic [BD-1:0]       col_q, col_d;
  logic [BD-1:0]       row_q, row_d;
  logic [9:0]          bcol_q, bcol_d;
  logic [AW-1:0]       blk_base_q, blk_base_d;
  logic [AW-1:0]       line_base_q, line_base_d;
  logic [AW-1:0]       count_q, count_d;
  logic                cfg_err_q, cfg_err_d;
  logic                overflow_q, overflow_d;
  logic                short_frame_q, short_frame_d;
  logic [Amba_Word-1:0] prdata_q, prdata_d;

  logic [DD-1:0]       bank_q [DEPTH];

  logic                cfg_ok;
  logic [AW-1:0]       np_in_w, m_in_w, np_w, m_w;
  logic [AW-1:0]       px_addr;
  logic                px_we;
  logic                rd_en;
  logic [AW-1:0]       rd_limit;
  logic [Amba_Word-1:0] rd_word, rd_val;

  assign np_in_w = AW'(Np);
  assign m_in_w  = AW'(M);
  assign np_w    = AW'(np_q);
  assign m_w     = AW'(m_q);
  assign cfg_ok  = (M != '0) && (Np <= 10'(Max_Img_Size)) && ((Np % 10'(M)) == 10'd0);
  assign px_addr = line_base_q + AW'(col_q);
  assign rd_en   = PSEL && !PENABLE && !PWRITE;

  always_comb begin
    state_d       = state_q;
    np_d          = np_q;
    m_d           = m_q;
    nb_d          = nb_q;
    npsq_d        = npsq_q;
    stride_d      = stride_q;
    col_d         = col_q;
    row_d         = row_q;
    bcol_d        = bcol_q;
    blk_base_d    = blk_base_q;
    line_base_d   = line_base_q;
    count_d       = count_q;
    cfg_err_d     = cfg_err_q;
    overflow_d    = overflow_q;
    short_frame_d = short_frame_q;
    px_we         = 1'b0;
    if (cfg_load) begin
      col_d       = '0;
      row_d       = '0;
      bcol_d      = '0;
      blk_base_d  = '0;
      line_base_d = '0;
      count_d     = '0;
      if (cfg_ok) begin
        state_d  = S_COLLECT;
        np_d     = Np;
        m_d      = M;
        nb_d     = Np / 10'(M);
        npsq_d   = np_in_w * np_in_w;
        stride_d = np_in_w * (m_in_w - AW'(1)) + m_in_w;
      end else begin
        state_d   = S_IDLE;
        cfg_err_d = 1'b1;
      end
    end else if (state_q == S_COLLECT) begin
      if (new_pixel) begin
        px_we   = (px_addr < AW'(DEPTH));
        count_d = count_q + AW'(1);
        if (col_q == m_q - BD'(1)) begin
          col_d       = '0;
          line_base_d = line_base_q + np_w;
          if (row_q == m_q - BD'(1)) begin
            // End of block: jump to the next block, or to the next block row after the last column.
            row_d = '0;
            if (bcol_q == nb_q - 10'd1) begin
              blk_base_d = blk_base_q + stride_q;
              bcol_d     = '0;
            end else begin
              blk_base_d = blk_base_q + m_w;
              bcol_d     = bcol_q + 10'd1;
            end
            line_base_d = blk_base_d;
          end else begin
            row_d = row_q + BD'(1);
          end
        end else begin
          col_d = col_q + BD'(1);
        end
        if (count_d == npsq_q) state_d = S_READY;
      end
      if (Image_Done && state_d != S_READY) begin
        short_frame_d = 1'b1;
        state_d       = S_IDLE;
      end
    end else if (new_pixel) begin
      overflow_d = 1'b1;
    end
  end

`ifdef REORDER_PACK_EN
  localparam int IW = AW + 8;
  logic [IW-1:0] pidx [P];

  always_comb begin
    rd_word  = '0;
    rd_limit = (npsq_q + AW'(P - 1)) / AW'(P);
    for (int j = 0; j < P; j++) begin
      pidx[j] = IW'(PADDR) * IW'(P) + IW'(j);
      if (pidx[j] < IW'(npsq_q)) rd_word[j*DD +: DD] = bank_q[pidx[j][BA_W-1:0]];
    end
  end
`else
  logic [BA_W-1:0] rd_idx;

  always_comb begin
    rd_limit = npsq_q;
    rd_idx   = (PADDR < npsq_q) ? PADDR[BA_W-1:0] : '0;
    rd_word  = Amba_Word'(bank_q[rd_idx]);
  end
`endif

  always_comb begin
    rd_val   = (state_q == S_READY && PADDR < rd_limit) ? rd_word : '0;
    prdata_d = rd_en ? rd_val : prdata_q;
  end

  always_ff @(posedge clk) begin
    if (px_we && !rst) bank_q[px_addr[BA_W-1:0]] <= Pixel_Data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      np_q          <= '0;
      m_q           <= '0;
      nb_q          <= '0;
      npsq_q        <= '0;
      stride_q      <= '0;
      col_q         <= '0;
      row_q         <= '0;
      bcol_q        <= '0;
      blk_base_q    <= '0;
      line_base_q   <= '0;
      count_q       <= '0;
      cfg_err_q     <= 1'b0;
      overflow_q    <= 1'b0;
      short_frame_q <= 1'b0;
      prdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      np_q          <= np_d;
      m_q           <= m_d;
      nb_q          <= nb_d;
      npsq_q        <= npsq_d;
      stride_q      <= stride_d;
      col_q         <= col_d;
      row_q         <= row_d;
      bcol_q        <= bcol_d;
      blk_base_q    <= blk_base_d;
      line_base_q   <= line_base_d;
      count_q       <= count_d;
      cfg_err_q     <= cfg_err_d;
      overflow_q    <= overflow_d;
      short_frame_q <= short_frame_d;
      prdata_q      <= prdata_d;
    end
  end

  assign PRDATA      = prdata_q;
  assign frame_ready = (state_q == S_READY);
  assign cfg_err     = cfg_err_q;
  assign overflow    = overflow_q;
  assign short_frame = short_frame_q;

endmodule

// File: tb/tb_wm_block_raster_collector.sv
// Bench for wm_block_raster_collector: directed sequence with random frames checked against a block-to-raster model.
module tb_wm_block_raster_collector;

  logic        clk = 1'b0;
  logic        rst, cfg_load, new_pixel, Image_Done, PSEL, PENABLE, PWRITE;
  logic [9:0]  Np;
  logic [6:0]  M;
  logic [7:0]  Pixel_Data;
  logic [19:0] PADDR;
  logic [15:0] PRDATA;
  logic        frame_ready, cfg_err, overflow, short_frame;

  wm_block_raster_collector dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .Np(Np), .M(M),
    .new_pixel(new_pixel), .Pixel_Data(Pixel_Data), .Image_Done(Image_Done),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PRDATA(PRDATA), .frame_ready(frame_ready), .cfg_err(cfg_err),
    .overflow(overflow), .short_frame(short_frame)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: image as a plain array, state as 0=idle 1=collect 2=ready.
  logic [7:0] mbank [0:4095];
  int  cur_np, cur_m, mst, mcnt;
  bit  e_cfg, e_ovf, e_short;

`ifdef REORDER_PACK_EN
  localparam bit PACKED = 1'b1;
`else
  localparam bit PACKED = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int raster(input int n, input int np, input int m);
    int b, w, nbk;
    b   = n / (m * m);
    w   = n % (m * m);
    nbk = np / m;
    return ((b / nbk) * m + w / m) * np + (b % nbk) * m + (w % m);
  endfunction

  function automatic int n_words();
    return PACKED ? (cur_np * cur_np + 1) / 2 : cur_np * cur_np;
  endfunction

  function automatic logic [15:0] exp_word(input int k);
    logic [15:0] w;
    w = '0;
    if (mst != 2 || k >= n_words()) return w;
    if (PACKED) begin
      for (int j = 0; j < 2; j++)
        if (k * 2 + j < cur_np * cur_np) w[j*8 +: 8] = mbank[k * 2 + j];
    end else begin
      w[7:0] = mbank[k];
    end
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mst = 0; mcnt = 0; e_cfg = 0; e_ovf = 0; e_short = 0;
  endtask

  task automatic cfg(input int np, input int m, input bit with_pixel);
    Np = 10'(np); M = 7'(m);
    cfg_load = 1'b1; new_pixel = with_pixel; Pixel_Data = 8'h5A;
    tick();
    cfg_load = 1'b0; new_pixel = 1'b0;
    mcnt = 0;
    if (m != 0 && np <= 720 && np % m == 0) begin
      cur_np = np; cur_m = m; mst = 1;
    end else begin
      e_cfg = 1; mst = 0;
    end
  endtask

  task automatic pixel(input logic [7:0] v, input bit done);
    new_pixel = 1'b1; Pixel_Data = v; Image_Done = done;
    tick();
    new_pixel = 1'b0; Image_Done = 1'b0;
    if (mst == 1) begin
      mbank[raster(mcnt, cur_np, cur_m)] = v;
      mcnt++;
      if (mcnt == cur_np * cur_np) mst = 2;
      else if (done) begin e_short = 1; mst = 0; end
    end else begin
      e_ovf = 1;
    end
  endtask

  task automatic send_random(input int n, input bit done_on_last);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      pixel(8'($urandom), done_on_last && (i == n - 1));
    end
  endtask

  task automatic apb_read(input int k, output logic [15:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 20'(k);
    tick();
    d = PRDATA;
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, ".frame_ready"}, 32'(frame_ready), 32'(mst == 2));
    chk({tag, ".cfg_err"},     32'(cfg_err),     32'(e_cfg));
    chk({tag, ".overflow"},    32'(overflow),    32'(e_ovf));
    chk({tag, ".short_frame"}, 32'(short_frame), 32'(e_short));
  endtask

  task automatic check_image(input string tag);
    logic [15:0] d;
    for (int k = 0; k <= n_words(); k++) begin
      apb_read(k, d);
      chk($sformatf("%s.w%0d", tag, k), 32'(d), 32'(exp_word(k)));
    end
  endtask

  initial begin
    logic [15:0] d;
    int cfgs_np [7] = '{8, 12, 10, 16, 12, 18, 6};
    int cfgs_m  [7] = '{2, 4, 5, 8, 1, 6, 6};
    rst = 1'b1; cfg_load = 1'b0; new_pixel = 1'b0; Image_Done = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0;
    Np = '0; M = '0; Pixel_Data = '0;
    cur_np = 6; cur_m = 3;
    for (int i = 0; i < 4096; i++) mbank[i] = '0;

    do_reset();
    chk("reset.PRDATA", 32'(PRDATA), 32'h0);
    check_flags("reset");
    apb_read(0, d);
    chk("idle.read0", 32'(d), 32'h0);

    // Reference frame 0..35 in block order.
    cfg(6, 3, 1'b0);
    for (int n = 0; n < 36; n++) begin
      pixel(8'(n), 1'b0);
      if (n == 34) chk("fr_before_last", 32'(frame_ready), 32'h0);
      if (n == 35) chk("fr_after_last", 32'(frame_ready), 32'h1);
    end
    if (PACKED) begin
      apb_read(0, d);  chk("pk.w0", 32'(d), 32'h0100);
      apb_read(1, d);  chk("pk.w1", 32'(d), 32'h0902);
      apb_read(17, d); chk("pk.w17", 32'(d), 32'h2322);
    end else begin
      apb_read(0, d);  chk("un.w0", 32'(d), 32'd0);
      apb_read(1, d);  chk("un.w1", 32'(d), 32'd1);
      apb_read(2, d);  chk("un.w2", 32'(d), 32'd2);
      apb_read(3, d);  chk("un.w3", 32'(d), 32'd9);
      apb_read(6, d);  chk("un.w6", 32'(d), 32'd3);
      apb_read(35, d); chk("un.w35", 32'(d), 32'd35);
    end
    check_flags("frame1");
    check_image("img1");

    // Pixel while READY is dropped and flagged.
    pixel(8'hAA, 1'b0);
    check_flags("ovf");
    apb_read(0, d);
    chk("ovf.w0", 32'(d), PACKED ? 32'h0100 : 32'h0);

    // Random frames; the second is restarted part-way by a fresh cfg_load.
    for (int r = 0; r < 3; r++) begin
      int c;
      c = $urandom_range(0, 6);
      cfg(cfgs_np[c], cfgs_m[c], 1'b0);
      if (r == 1) begin
        send_random($urandom_range(3, 20), 1'b0);
        check_flags($sformatf("mid%0d", r));
        cfg(cfgs_np[c], cfgs_m[c], 1'b0);
      end
      send_random(cfgs_np[c] * cfgs_np[c], 1'b0);
      check_flags($sformatf("rnd%0d", r));
      check_image($sformatf("rnd%0d", r));
    end

    // Short frame.
    cfg(6, 3, 1'b0);
    send_random(20, 1'b0);
    Image_Done = 1'b1;
    tick();
    Image_Done = 1'b0;
    if (mst == 1) begin e_short = 1; mst = 0; end
    check_flags("short");
    apb_read(0, d);
    chk("short.w0", 32'(d), 32'h0);

    // Reset mid-frame, then a clean frame with cfg_load+pixel collision and Image_Done on the last pixel.
    cfg(6, 3, 1'b0);
    send_random(10, 1'b0);
    do_reset();
    check_flags("rst_mid");
    cfg(6, 3, 1'b1);
    send_random(36, 1'b1);
    check_flags("after_rst");
    check_image("after_rst");

    // Illegal configuration.
    cfg(7, 3, 1'b0);
    check_flags("cfg_bad");
    pixel(8'h33, 1'b0);
    check_flags("cfg_bad_px");
    apb_read(0, d);
    chk("cfg_bad.w0", 32'(d), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
